// File: rtl/mux_arb_nne1.sv
// N-to-1 valid/ready multiplexer with a fixed-priority or round-robin arbiter
// feeding a one-entry output register that sustains one word per cycle.
module mux_arb_nne1 #(
    parameter int WIDTH = 3,
    parameter int N     = 4,
    parameter int MODE  = 0,
    localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [N*WIDTH-1:0]   Hyrjet,
    input  logic [N-1:0]         HyrjaValid,
    output logic [N-1:0]         HyrjaReady,
    output logic [WIDTH-1:0]     Dalja,
    output logic                 DaljaValid,
    input  logic                 DaljaReady,
    output logic [SW-1:0]        Zgjedhja
);

    logic [WIDTH-1:0] data_q,  data_d;
    logic             valid_q, valid_d;
    logic [SW-1:0]    sel_q,   sel_d;
    logic [SW-1:0]    ptr_q,   ptr_d;

    logic             load;
    logic             any_valid;
    logic             fp_found;
    logic [SW-1:0]    fp_idx;
    logic             rr_found;
    logic [SW-1:0]    rr_idx;
    logic [SW-1:0]    grant_idx;
    logic             grant_en;
    logic [WIDTH-1:0] grant_data;
    int               cand;

    // The register can accept a word when empty or when its word leaves this cycle.
    assign load      = !valid_q || DaljaReady;
    assign any_valid = |HyrjaValid;
    assign grant_en  = load && any_valid && !Reset;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        fp_found = 1'b0;
        fp_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!fp_found && HyrjaValid[i]) begin
                fp_found = 1'b1;
                fp_idx   = SW'(i);
            end
        end
    end

    // Round-robin search starts just past the last accepted channel, wrapping around.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr_q) + 1 + k) % N;
            if (!rr_found && HyrjaValid[cand]) begin
                rr_found = 1'b1;
                rr_idx   = SW'(cand);
            end
        end
    end

    always_comb begin
        grant_idx  = (MODE == 1) ? rr_idx : fp_idx;
        grant_data = '0;
        HyrjaReady = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SW'(i)) begin
                grant_data    = Hyrjet[i*WIDTH +: WIDTH];
                HyrjaReady[i] = grant_en;
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (grant_en) begin
            data_d  = grant_data;
            sel_d   = grant_idx;
            valid_d = 1'b1;
            ptr_d   = grant_idx;
        end else if (valid_q && DaljaReady) begin
            // Drained with nothing to refill: data and index keep their last values.
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
            ptr_q   <= SW'(N - 1);
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign Dalja      = data_q;
    assign DaljaValid = valid_q;
    assign Zgjedhja   = sel_q;

endmodule

// File: tb/tb_mux_arb_nne1.sv
// Directed bench for mux_arb_nne1: one fixed-priority and one round-robin instance,
// driven from shared clock and reset with hand-computed expectations.
module tb_mux_arb_nne1;

    logic        clk;
    logic        rst;

    logic [11:0] fp_in;
    logic [3:0]  fp_v;
    logic [3:0]  fp_rdy;
    logic [2:0]  fp_dout;
    logic        fp_dv;
    logic        fp_dr;
    logic [1:0]  fp_sel;

    logic [11:0] rr_in;
    logic [3:0]  rr_v;
    logic [3:0]  rr_rdy;
    logic [2:0]  rr_dout;
    logic        rr_dv;
    logic        rr_dr;
    logic [1:0]  rr_sel;

    int n_checks = 0;
    int n_pass   = 0;

    mux_arb_nne1 #(.WIDTH(3), .N(4), .MODE(0)) u_fp (
        .Clock      (clk),
        .Reset      (rst),
        .Hyrjet     (fp_in),
        .HyrjaValid (fp_v),
        .HyrjaReady (fp_rdy),
        .Dalja      (fp_dout),
        .DaljaValid (fp_dv),
        .DaljaReady (fp_dr),
        .Zgjedhja   (fp_sel)
    );

    mux_arb_nne1 #(.WIDTH(3), .N(4), .MODE(1)) u_rr (
        .Clock      (clk),
        .Reset      (rst),
        .Hyrjet     (rr_in),
        .HyrjaValid (rr_v),
        .HyrjaReady (rr_rdy),
        .Dalja      (rr_dout),
        .DaljaValid (rr_dv),
        .DaljaReady (rr_dr),
        .Zgjedhja   (rr_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with every channel valid on both instances.
        rst   = 1'b1;
        fp_in = {3'd4, 3'd3, 3'd2, 3'd1};
        rr_in = {3'd4, 3'd3, 3'd2, 3'd1};
        fp_v  = 4'b1111;
        rr_v  = 4'b1111;
        fp_dr = 1'b1;
        rr_dr = 1'b1;
        step();
        step();
        check("rst_fp_dv",   32'(fp_dv),   32'd0);
        check("rst_fp_dout", 32'(fp_dout), 32'd0);
        check("rst_fp_sel",  32'(fp_sel),  32'd0);
        check("rst_fp_rdy",  32'(fp_rdy),  32'd0);
        check("rst_rr_rdy",  32'(rr_rdy),  32'd0);
        check("rst_rr_dv",   32'(rr_dv),   32'd0);
        rst  = 1'b0;
        fp_v = 4'b0000;
        rr_v = 4'b0000;
        #1;
        check("idle_fp_rdy", 32'(fp_rdy), 32'd0);

        // Single source on channel 2.
        fp_in = 12'b000_101_000_000;
        fp_v  = 4'b0100;
        #1;
        check("single_rdy", 32'(fp_rdy), 32'b0100);
        step();
        check("single_dout", 32'(fp_dout), 32'd5);
        check("single_sel",  32'(fp_sel),  32'd2);
        check("single_dv",   32'(fp_dv),   32'd1);

        // Fixed priority: channel 1 always beats channel 3.
        fp_in = {3'd7, 3'd0, 3'd3, 3'd0};
        fp_v  = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("fp_rdy", 32'(fp_rdy), 32'b0010);
            step();
            check("fp_sel",  32'(fp_sel),  32'd1);
            check("fp_dout", 32'(fp_dout), 32'd3);
        end
        // Drain with no refill: valid drops, data and index hold.
        fp_v = 4'b0000;
        step();
        check("drain_dv",   32'(fp_dv),   32'd0);
        check("drain_dout", 32'(fp_dout), 32'd3);
        check("drain_sel",  32'(fp_sel),  32'd1);
        // Ready with an empty register has no effect.
        step();
        check("empty_dv", 32'(fp_dv), 32'd0);

        // Round-robin with all channels valid: 0,1,2,3,0,1 back to back.
        rr_v  = 4'b1111;
        rr_dr = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_rdy", 32'(rr_rdy), 32'(1 << (k % 4)));
            step();
            check("rr_sel",  32'(rr_sel),  32'(k % 4));
            check("rr_dout", 32'(rr_dout), 32'((k % 4) + 1));
            check("rr_dv",   32'(rr_dv),   32'd1);
        end

        // Backpressure for three cycles while holding channel 1's word.
        rr_dr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_rdy", 32'(rr_rdy), 32'd0);
            step();
            check("stall_dout", 32'(rr_dout), 32'd2);
            check("stall_sel",  32'(rr_sel),  32'd1);
            check("stall_dv",   32'(rr_dv),   32'd1);
        end
        rr_dr = 1'b1;
        #1;
        check("resume_rdy", 32'(rr_rdy), 32'b0100);
        step();
        check("resume_sel",  32'(rr_sel),  32'd2);
        check("resume_dout", 32'(rr_dout), 32'd3);

        // Hold a 6 on channel 3, stall, then reset mid-stall.
        rr_in = {3'd6, 3'd3, 3'd2, 3'd1};
        rr_v  = 4'b1000;
        step();
        check("hold6_sel",  32'(rr_sel),  32'd3);
        check("hold6_dout", 32'(rr_dout), 32'd6);
        rr_dr = 1'b0;
        rr_v  = 4'b1111;
        step();
        check("hold6_stall", 32'(rr_dout), 32'd6);
        rst = 1'b1;
        #1;
        check("midrst_rdy", 32'(rr_rdy), 32'd0);
        step();
        check("midrst_dv",   32'(rr_dv),   32'd0);
        check("midrst_dout", 32'(rr_dout), 32'd0);
        check("midrst_sel",  32'(rr_sel),  32'd0);
        rst   = 1'b0;
        rr_dr = 1'b1;
        #1;
        check("post_rst_rdy", 32'(rr_rdy), 32'b0001);
        step();
        check("post_rst_sel",  32'(rr_sel),  32'd0);
        check("post_rst_dout", 32'(rr_dout), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
